// File: rtl/card_count_pkg.sv
// +----------------------------------------------------------------------+
// | card_count_pkg                                                       |
// | Shared types, constants, register map and Hi-Lo mapping.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package card_count_pkg;

   localparam int NUM_CLASSES   = 53;
   localparam int NO_CARD_CLASS = 52;
   localparam int RANKS         = 13;

   localparam logic [2:0] ADDR_LAST_CLASS = 3'd0;
   localparam logic [2:0] ADDR_LAST_SCORE = 3'd1;
   localparam logic [2:0] ADDR_COUNT      = 3'd2;
   localparam logic [2:0] ADDR_CARDS      = 3'd3;
   localparam logic [2:0] ADDR_STATUS     = 3'd4;
   localparam logic [2:0] ADDR_CTRL       = 3'd5;

   typedef logic signed [7:0] logit_t;
   typedef logic [5:0]        class_t;

   // Classes are suit*13+rank_idx, so the rank is the class modulo 13.
   function automatic logic signed [1:0] hilo_value(input class_t cls);
      class_t rank;
      rank = cls % class_t'(RANKS);
      if (rank >= 6'd1 && rank <= 6'd5)
         return 2'sb01;
      else if (rank >= 6'd6 && rank <= 6'd8)
         return 2'sb00;
      else
         return 2'sb11;
   endfunction

endpackage

`default_nettype wire

// File: rtl/card_count_engine_argmax_stream.sv
// +----------------------------------------------------------------------+
// | argmax_stream                                                        |
// | Streaming argmax over one frame of logits with frame-length check.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module argmax_stream #(
   parameter int NUM_CLASSES = card_count_pkg::NUM_CLASSES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic signed [7:0]     s_data,
   input  logic                  s_last,
   output logic                  done,
   output logic                  frame_err,
   output card_count_pkg::class_t best_idx,
   output card_count_pkg::logit_t best_score
);
   import card_count_pkg::*;

   typedef enum logic [0:0] {
      ST_ACCUM  = 1'b0,
      ST_COMMIT = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_next;
   class_t r_idx;
   class_t r_best_idx;
   logit_t r_best_score;
   logic   r_err;
   logic   w_accept;
   logic   w_at_end;

   assign w_accept = s_valid && (r_state == ST_ACCUM);
   assign w_at_end = (r_idx == class_t'(NUM_CLASSES - 1));

   always_comb begin
      w_state_next = r_state;
      s_ready      = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            s_ready = 1'b1;
            if (w_accept && (s_last || w_at_end))
               w_state_next = ST_COMMIT;
         end
         ST_COMMIT: begin
            done         = 1'b1;
            w_state_next = ST_ACCUM;
         end
         default: w_state_next = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_ACCUM;
         r_idx        <= '0;
         r_best_idx   <= '0;
         r_best_score <= 8'sh80;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_COMMIT) begin
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_score <= 8'sh80;
         end else if (w_accept) begin
            r_idx <= r_idx + 6'd1;
            // Strict compare keeps the lowest index on ties.
            if (s_data > r_best_score) begin
               r_best_score <= s_data;
               r_best_idx   <= r_idx;
            end
            r_err <= !(s_last && w_at_end);
         end
      end
   end

   assign frame_err  = r_err;
   assign best_idx   = r_best_idx;
   assign best_score = r_best_score;

endmodule

`default_nettype wire

// File: rtl/card_count_engine.sv
// +----------------------------------------------------------------------+
// | card_count_engine                                                    |
// | Debounced card detection, Hi-Lo running count, Avalon-MM registers.  |
// | Optional irq output when CARD_COUNT_IRQ_EN is defined.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module card_count_engine #(
   parameter int                     NUM_CLASSES   = card_count_pkg::NUM_CLASSES,
   parameter int                     STABLE_FRAMES = 3,
   parameter card_count_pkg::logit_t MIN_SCORE     = 8'sd16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic signed [7:0] s_data,
   input  logic              s_last,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write,
   input  logic [2:0]        address,
   input  logic [7:0]        writedata,
   output logic [7:0]        readdata
`ifdef CARD_COUNT_IRQ_EN
   ,
   output logic              irq
`endif
);
   import card_count_pkg::*;

   localparam logit_t c_count_max = 8'sh7F;
   localparam logit_t c_count_min = 8'sh80;

   logic                w_done;
   logic                w_frame_err;
   class_t              w_best_idx;
   logit_t              w_best_score;
   class_t              w_result;
   logic                w_commit;
   logic                w_same;
   logic [3:0]          w_stab_next;
   logic                w_armed_eff;
   logic                w_count_evt;
   logic signed [1:0]   w_hilo;
   logic                w_wr_ctrl;
   logic                w_clr_all;
   logic                w_clr_err;
   logic                w_rd;
   logic                w_rd_status;
   logic                w_unused_wdata;

   class_t              r_last_class;
   logit_t              r_last_score;
   logit_t              r_count;
   logic [7:0]          r_cards;
   class_t              r_prev;
   logic [3:0]          r_stab;
   logic                r_armed;
   logic                r_err;
   logic                r_new;

   argmax_stream #(
      .NUM_CLASSES (NUM_CLASSES)
   ) u_argmax (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .done       (w_done),
      .frame_err  (w_frame_err),
      .best_idx   (w_best_idx),
      .best_score (w_best_score)
   );

   assign w_result    = (w_best_score < MIN_SCORE) ? class_t'(NO_CARD_CLASS) : w_best_idx;
   assign w_commit    = w_done && !w_frame_err;
   assign w_same      = (w_result == r_prev);
   assign w_stab_next = w_same ? ((r_stab == 4'hF) ? r_stab : r_stab + 4'd1) : 4'd1;
   assign w_armed_eff = !w_same || r_armed;
   assign w_count_evt = w_commit && w_armed_eff && (w_stab_next == 4'(STABLE_FRAMES))
                        && (w_result != class_t'(NO_CARD_CLASS));
   assign w_hilo      = hilo_value(w_result);

   assign w_wr_ctrl      = chipselect && write && (address == ADDR_CTRL);
   assign w_clr_all      = w_wr_ctrl && writedata[0];
   assign w_clr_err      = w_wr_ctrl && writedata[1];
   assign w_rd           = chipselect && read;
   assign w_rd_status    = w_rd && (address == ADDR_STATUS);
   assign w_unused_wdata = &{1'b0, writedata[7:2]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_class <= '0;
         r_last_score <= '0;
         r_count      <= '0;
         r_cards      <= '0;
         r_prev       <= '0;
         r_stab       <= '0;
         r_armed      <= 1'b0;
         r_err        <= 1'b0;
         r_new        <= 1'b0;
      end else begin
         if (w_commit) begin
            r_last_class <= w_result;
            r_last_score <= w_best_score;
         end
         // Setting NEW takes priority over the clear-on-read.
         if (w_commit)
            r_new <= 1'b1;
         else if (w_rd_status)
            r_new <= 1'b0;

         if (w_clr_all) begin
            r_count <= '0;
            r_cards <= '0;
            r_prev  <= '0;
            r_stab  <= '0;
            r_armed <= 1'b1;
            r_err   <= 1'b0;
         end else begin
            if (w_commit) begin
               r_prev  <= w_result;
               r_stab  <= w_stab_next;
               r_armed <= w_count_evt ? 1'b0 : w_armed_eff;
            end
            if (w_count_evt) begin
               if (w_hilo == 2'sb01 && r_count != c_count_max)
                  r_count <= r_count + 8'sd1;
               else if (w_hilo == 2'sb11 && r_count != c_count_min)
                  r_count <= r_count - 8'sd1;
               if (r_cards != 8'hFF)
                  r_cards <= r_cards + 8'd1;
            end
            if (w_done && w_frame_err)
               r_err <= 1'b1;
            else if (w_clr_err)
               r_err <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= 8'h00;
      end else if (w_rd) begin
         case (address)
            ADDR_LAST_CLASS: readdata <= {2'b00, r_last_class};
            ADDR_LAST_SCORE: readdata <= r_last_score;
            ADDR_COUNT:      readdata <= r_count;
            ADDR_CARDS:      readdata <= r_cards;
            ADDR_STATUS:     readdata <= {5'b00000, r_armed, r_err, r_new};
            default:         readdata <= 8'h00;
         endcase
      end
   end

`ifdef CARD_COUNT_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset)
         irq <= 1'b0;
      else if (w_count_evt && !w_clr_all)
         irq <= 1'b1;
      else if (w_rd_status)
         irq <= 1'b0;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_card_count_engine.sv
// +----------------------------------------------------------------------+
// | tb_card_count_engine                                                 |
// | Directed self-checking bench for card_count_engine.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_card_count_engine;

   logic              clk = 1'b0;
   logic              reset;
   logic              s_valid;
   logic              s_ready;
   logic signed [7:0] s_data;
   logic              s_last;
   logic              chipselect;
   logic              read;
   logic              write;
   logic [2:0]        address;
   logic [7:0]        writedata;
   logic [7:0]        readdata;

   int                errors = 0;
   int                checks = 0;
   int                ready_miss = 0;
   logic              commit_ready;
   logic signed [7:0] logits [0:52];

   always #5 clk = ~clk;

   card_count_engine dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .chipselect (chipselect),
      .read       (read),
      .write      (write),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill(input int cls, input int val, input int other);
      for (int i = 0; i < 53; i++) logits[i] = 8'(other);
      logits[cls] = 8'(val);
   endtask

   // Returns one cycle after COMMIT, when the registers have just updated.
   task automatic send_frame(input int nbeats, input int last_at, input bit clr_in_commit);
      for (int b = 0; b < nbeats; b++) begin
         s_valid = 1'b1;
         s_data  = logits[b];
         s_last  = (b == last_at);
         if (s_ready !== 1'b1) ready_miss++;
         @(posedge clk); #1;
      end
      s_valid      = 1'b0;
      s_last       = 1'b0;
      commit_ready = s_ready;
      if (clr_in_commit) begin
         chipselect = 1'b1; write = 1'b1; address = 3'd5; writedata = 8'h01;
      end
      @(posedge clk); #1;
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
      check(tag, {24'd0, readdata}, {24'd0, exp});
   endtask

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, s_ready}, 1);
      check("rst_readdata", {24'd0, readdata}, 0);
      reset = 1'b0;
      check_reg("rst_count", 3'd2, 8'h00);
      check_reg("rst_status", 3'd4, 8'h00);

      // Three stable class-1 frames (rank 1 -> +1)
      fill(1, 40, -5);
      send_frame(53, 52, 1'b0);
      check("commit_ready_low", {31'd0, commit_ready}, 0);
      check("ready_after_commit", {31'd0, s_ready}, 1);
      send_frame(53, 52, 1'b0);
      send_frame(53, 52, 1'b0);
      check_reg("last_class_c1", 3'd0, 8'd1);
      check_reg("last_score_c1", 3'd1, 8'd40);
      check_reg("count_1", 3'd2, 8'd1);
      check_reg("cards_1", 3'd3, 8'd1);
      check_reg("status_new", 3'd4, 8'h01);
      check_reg("status_new_cleared", 3'd4, 8'h00);
      check_reg("reg6_zero", 3'd6, 8'h00);

      repeat (5) send_frame(53, 52, 1'b0);
      check_reg("count_hold", 3'd2, 8'd1);
      check_reg("cards_hold", 3'd3, 8'd1);

      fill(0, 0, 0);
      send_frame(53, 52, 1'b0);
      check_reg("nocard_class", 3'd0, 8'd52);
      check_reg("nocard_status", 3'd4, 8'h05);
      check_reg("nocard_cards", 3'd3, 8'd1);

      fill(1, 40, -5);
      repeat (3) send_frame(53, 52, 1'b0);
      check_reg("count_2", 3'd2, 8'd2);
      check_reg("cards_2", 3'd3, 8'd2);

      // Tie between classes 10 and 23
      fill(10, 50, -5);
      logits[23] = 8'sd50;
      send_frame(53, 52, 1'b0);
      check_reg("tie_class", 3'd0, 8'd10);
      check_reg("tie_status", 3'd4, 8'h05);

      // Early s_last at beat 30
      fill(5, 60, -5);
      send_frame(31, 30, 1'b0);
      check_reg("err_status", 3'd4, 8'h06);
      check_reg("err_class", 3'd0, 8'd10);
      check_reg("err_score", 3'd1, 8'd50);
      send_frame(53, 52, 1'b0);
      check_reg("post_err_class", 3'd0, 8'd5);
      check_reg("post_err_score", 3'd1, 8'd60);
      check_reg("post_err_status", 3'd4, 8'h07);
      bus_write(3'd5, 8'h02);
      check_reg("err_cleared", 3'd4, 8'h04);

      // Missing s_last
      fill(7, 60, -5);
      send_frame(53, 99, 1'b0);
      check_reg("nolast_status", 3'd4, 8'h06);
      check_reg("nolast_class", 3'd0, 8'd5);
      check_reg("count_after_err", 3'd2, 8'd2);

      // Saturation: 130 counted +1 cards
      bus_write(3'd5, 8'h01);
      check_reg("clr_count", 3'd2, 8'h00);
      check_reg("clr_status", 3'd4, 8'h04);
      for (int k = 0; k < 130; k++) begin
         fill((k % 2 == 1) ? 2 : 1, 40, -5);
         repeat (3) send_frame(53, 52, 1'b0);
      end
      check_reg("sat_count", 3'd2, 8'd127);
      check_reg("sat_cards", 3'd3, 8'd130);

      // Clear write coinciding with a counting COMMIT
      fill(3, 40, -5);
      repeat (2) send_frame(53, 52, 1'b0);
      check_reg("pre_cc_status", 3'd4, 8'h05);
      send_frame(53, 52, 1'b1);
      check_reg("cc_count", 3'd2, 8'h00);
      check_reg("cc_cards", 3'd3, 8'h00);
      check_reg("cc_class", 3'd0, 8'd3);
      check_reg("cc_status", 3'd4, 8'h05);

      // Rank 0 -> -1, rank 7 -> 0
      fill(13, 40, -5);
      repeat (3) send_frame(53, 52, 1'b0);
      check_reg("rank0_count", 3'd2, 8'hFF);
      fill(7, 40, -5);
      repeat (3) send_frame(53, 52, 1'b0);
      check_reg("rank7_count", 3'd2, 8'hFF);
      check_reg("rank7_cards", 3'd3, 8'd2);

      // Reset after a partial frame
      fill(9, 40, -5);
      send_frame(20, 99, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      fill(11, 40, -5);
      send_frame(53, 52, 1'b0);
      check_reg("post_rst_class", 3'd0, 8'd11);
      check_reg("post_rst_status", 3'd4, 8'h03 & 8'h01 | 8'h04);
      check_reg("post_rst_count", 3'd2, 8'h00);

      check("ready_miss", ready_miss, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/card_count_engine.md
Name: card_count_engine

Overview:
- Downstream of the CNN layer stack: consumes the 53 int8 logits the final FC layer emits per frame.
- Computes the argmax class and debounces it across frames.
- Maps each newly seen card to its Hi-Lo value and keeps a running count.
- Exposes results to the HPS through an 8-bit Avalon-MM slave, in the same style as the CNN memory peripheral.

Parameters:
- NUM_CLASSES, 53, logits per frame; classes 0..51 are cards (suit*13+rank_idx), class 52 is no-card.
- STABLE_FRAMES, 3, consecutive identical winning frames required before a card is counted (range 1..15).
- MIN_SCORE, 8'sd16, winning logit below this value forces the frame result to no-card.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- s_valid  in  1  logit beat valid
- s_ready  out  1  engine accepts beat
- s_data  in  8  signed logit
- s_last  in  1  final beat of frame
- chipselect  in  1  Avalon select
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- address  in  3  register index
- writedata  in  8  write data
- readdata  out  8  registered read data

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values:
  - s_ready=1, readdata=0.
  - All registers 0, except best score = -128.
  - Beat index = 0; FSM = ACCUM.
- FSM ACCUM:
  - A beat is accepted when s_valid && s_ready.
  - Strict ">" compare against best score, so ties keep the lowest index.
  - Beat index increments on each accepted beat.
- ACCUM -> COMMIT transitions:
  - On an accepted s_last.
  - On an accepted beat at index NUM_CLASSES-1 without s_last: this is a length error.
- FSM COMMIT (1 cycle):
  - s_ready=0.
  - Frame result = argmax, or 52 if best score < MIN_SCORE.
  - LAST_CLASS and LAST_SCORE update; NEW=1.
  - Next cycle: back to ACCUM, index=0, best score=-128.
- Latency: last beat accepted in cycle N -> registers visible in N+2; s_ready low in N+1 only.
- Length error (s_last at index != NUM_CLASSES-1, or missing s_last):
  - Set ERR; frame is discarded.
  - No class, score, NEW or stability update.
- Debounce:
  - Stability counter increments when the frame result equals the previous frame result; otherwise it reloads to 1.
  - A card class is counted once, when the counter reaches STABLE_FRAMES and the armed flag is set. Counting clears armed.
  - Armed is re-set when a different result appears (including 52).
  - Class 52 is never counted.
- Hi-Lo mapping on rank_idx = class mod 13:
  - 1..5 -> +1
  - 6..8 -> 0
  - 0, 9..12 -> -1
- COUNT: signed 8-bit, saturating at -128/+127.
- CARDS: unsigned 8-bit, saturating at 255.
- Registers (read latency 1 cycle; readdata holds its value when not reading):
  - 0 LAST_CLASS
  - 1 LAST_SCORE
  - 2 COUNT
  - 3 CARDS
  - 4 STATUS {5'b0, armed, ERR, NEW}; a read clears NEW
  - 5-7 read 0
- Writes:
  - Address 5, bit0=1: clear COUNT, CARDS, ERR, stability counter and previous result; armed=1.
  - Address 5, bit1=1: clear ERR only.
  - Other writes are ignored.
- Simultaneous events:
  - Clear write in the same cycle as COMMIT: the clear wins for COUNT, CARDS and stability; LAST_CLASS, LAST_SCORE and NEW still update.
  - STATUS read in the same cycle as NEW being set: NEW stays 1.
- Reset mid-frame: the partial frame is dropped and the next beat is index 0.

Optional Feature:
- Macro CARD_COUNT_IRQ_EN.
  - Defined: adds output irq. irq is set the cycle after a card is counted and cleared by a STATUS read or by reset.
  - Undefined: no irq port, no extra logic.

Decomposition:
- Package card_count_pkg holds:
  - NUM_CLASSES, NO_CARD_CLASS=52, RANKS=13
  - register address localparams
  - typedef logit_t (signed 8-bit)
  - typedef class_t (6-bit)
  - function hilo_value(class_t) returning signed 2-bit
- Sub-module argmax_stream holds the beat index, best score/index, last/length-error detection and the done pulse.
- Top level holds debounce, counting and bus logic.

Test Plan:
- 53-beat frame, logit 40 at class 1 (Ace rank group? no: rank_idx 1 = 2), others -5, repeated 3 frames -> COUNT=+1, CARDS=1; LAST_CLASS=1 readable 2 cycles after last beat.
- Same class-1 frames continued 5 more times -> COUNT stays +1; then one no-card frame (all logits 0 < MIN_SCORE), then 3 frames of class 1 -> COUNT=+2.
- Frame with max 50 at both class 10 and class 23 -> LAST_CLASS=10 (tie keeps lowest index).
- s_last asserted at beat 30 -> ERR=1, LAST_CLASS unchanged, NEW unchanged; next correct frame is processed normally.
- 130 counted +1 cards -> COUNT saturates at 127.
- Write 0x01 to address 5 in the COMMIT cycle of a counting frame -> COUNT=0, CARDS=0, NEW=1.
